// File: rtl/uart_bus_master.sv
// UART-driven debug bus initiator: 8N1 command frames in, one rd/wr strobe on the
// peripheral I/O bus, read data or write ack back out over UART TX.
module uart_bus_master #(
  parameter int unsigned CLKS_PER_BIT   = 434,
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] io_addr,
  output logic [15:0] io_dout,
  input  logic [15:0] io_din,
  output logic        io_rd,
  output logic        io_wr,
  output logic        busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ACK    = 8'h4B;

  typedef enum logic [3:0] {
    IDLE, GET_AH, GET_AL, GET_DH, GET_DL, REQ, STROBE, CAPTURE, SEND
  } state_t;

  // RX deframer: bit index 0 = start, 1..8 = data, 9 = stop
  logic          rx_s1, rx_s2, rx_prev, rx_active, rx_valid, rx_ferr;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_active <= 1'b0;
      rx_valid  <= 1'b0;
      rx_ferr   <= 1'b0;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_sh     <= '0;
    end else begin
      rx_s1    <= uart_rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (!rx_active) begin
        if (rx_prev && !rx_s2) begin
          rx_active <= 1'b1;
          rx_cnt    <= '0;
          rx_bit    <= '0;
        end
      end else if (rx_bit == 4'd0) begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt <= '0;
          if (rx_s2) rx_active <= 1'b0;
          else       rx_bit    <= 4'd1;
        end else begin
          rx_cnt <= rx_cnt + CW'(1);
        end
      end else if (rx_cnt == BIT_LAST) begin
        rx_cnt <= '0;
        if (rx_bit == 4'd9) begin
          rx_active <= 1'b0;
          rx_valid  <= rx_s2;
          rx_ferr   <= !rx_s2;
        end else begin
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 4'd1;
        end
      end else begin
        rx_cnt <= rx_cnt + CW'(1);
      end
    end
  end

  // TX serializer; a new byte may load on the last stop cycle for gapless output
  logic          tx_active, tx_load_c, tx_ready_c, tx_done_c;
  logic [7:0]    tx_byte_c;
  logic [8:0]    tx_sh;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;

  assign tx_done_c  = tx_active && (tx_cnt == BIT_LAST) && (tx_bit == 4'd9);
  assign tx_ready_c = !tx_active || tx_done_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_tx   <= 1'b1;
      tx_active <= 1'b0;
      tx_sh     <= '1;
      tx_cnt    <= '0;
      tx_bit    <= '0;
    end else if (tx_load_c) begin
      uart_tx   <= 1'b0;
      tx_active <= 1'b1;
      tx_sh     <= {1'b1, tx_byte_c};
      tx_cnt    <= '0;
      tx_bit    <= '0;
    end else if (tx_active) begin
      if (tx_cnt == BIT_LAST) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_active <= 1'b0;
          uart_tx   <= 1'b1;
        end else begin
          uart_tx <= tx_sh[0];
          tx_sh   <= {1'b1, tx_sh[8:1]};
          tx_bit  <= tx_bit + 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + CW'(1);
      end
    end
  end

  // Command sequencer
  state_t        state, state_d;
  logic          is_wr, is_wr_d, busy_d, bus_req_d, io_rd_d, io_wr_d;
  logic [15:0]   addr_d, dout_d, rd_data, rd_data_d;
  logic [1:0]    send_left, send_left_d;
  logic [TW-1:0] to_cnt, to_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      is_wr     <= 1'b0;
      busy      <= 1'b0;
      bus_req   <= 1'b0;
      io_rd     <= 1'b0;
      io_wr     <= 1'b0;
      io_addr   <= '0;
      io_dout   <= '0;
      rd_data   <= '0;
      send_left <= '0;
      to_cnt    <= '0;
    end else begin
      state     <= state_d;
      is_wr     <= is_wr_d;
      busy      <= busy_d;
      bus_req   <= bus_req_d;
      io_rd     <= io_rd_d;
      io_wr     <= io_wr_d;
      io_addr   <= addr_d;
      io_dout   <= dout_d;
      rd_data   <= rd_data_d;
      send_left <= send_left_d;
      to_cnt    <= to_cnt_d;
    end
  end

  always_comb begin
    state_d     = state;
    is_wr_d     = is_wr;
    busy_d      = busy;
    addr_d      = io_addr;
    dout_d      = io_dout;
    rd_data_d   = rd_data;
    send_left_d = send_left;
    to_cnt_d    = '0;
    tx_load_c   = 1'b0;
    tx_byte_c   = ACK;
    unique case (state)
      IDLE: begin
        if (rx_valid && (rx_byte_is(CMD_WR) || rx_byte_is(CMD_RD))) begin
          is_wr_d = rx_byte_is(CMD_WR);
          busy_d  = 1'b1;
          state_d = GET_AH;
        end
      end
      GET_AH, GET_AL, GET_DH, GET_DL: begin
        if (rx_ferr || (to_cnt == TO_LAST)) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (rx_valid) begin
          unique case (state)
            GET_AH:  begin addr_d = {rx_sh, io_addr[7:0]};  state_d = GET_AL; end
            GET_AL:  begin addr_d = {io_addr[15:8], rx_sh}; state_d = is_wr ? GET_DH : REQ; end
            GET_DH:  begin dout_d = {rx_sh, io_dout[7:0]};  state_d = GET_DL; end
            default: begin dout_d = {io_dout[15:8], rx_sh}; state_d = REQ; end
          endcase
        end else begin
          to_cnt_d = to_cnt + TW'(1);
        end
      end
      REQ: if (bus_gnt) state_d = STROBE;
      STROBE: begin
        if (is_wr) begin
          send_left_d = 2'd1;
          state_d     = SEND;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        rd_data_d   = io_din;
        send_left_d = 2'd2;
        state_d     = SEND;
      end
      SEND: begin
        if ((send_left != 2'd0) && tx_ready_c) begin
          tx_load_c   = 1'b1;
          tx_byte_c   = is_wr ? ACK : ((send_left == 2'd2) ? rd_data[15:8] : rd_data[7:0]);
          send_left_d = send_left - 2'd1;
        end else if ((send_left == 2'd0) && tx_done_c) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    bus_req_d = (state_d == REQ) || (state_d == STROBE) || (state_d == CAPTURE);
    io_rd_d   = (state_d == STROBE) && !is_wr_d;
    io_wr_d   = (state_d == STROBE) && is_wr_d;
  end

  function automatic logic rx_byte_is(input logic [7:0] b);
    return rx_sh == b;
  endfunction

endmodule
